sobel_pipe: RTL and testbench

Pipelined, parametrised Sobel gradient engine for the edge-detection datapath. It takes one 3x3 pixel window per accepted beat. For each window it produces a saturated gradient magnitude, a 2-bit quantised gradient direction and a threshold edge flag. Selectable norm modes, output scaling, a valid/ready handshake with back-pressure, and a user sideband (sof/eol) carried through at fixed latency.

---
 rtl/sobel_pipe.sv | 154 +++++++++++++++
 tb/tb_sobel_pipe.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_pipe.sv
// Three-stage Sobel gradient engine: S1 gx/gy, S2 abs/min/max/signs, S3 magnitude, direction and edge.
// All stages advance together on ~out_valid | out_ready, so back-pressure freezes the whole pipe.
module sobel_pipe #(
  parameter int PIX_W  = 8,
  parameter int USER_W = 2,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  p0,
  input  logic [PIX_W-1:0]  p1,
  input  logic [PIX_W-1:0]  p2,
  input  logic [PIX_W-1:0]  p3,
  input  logic [PIX_W-1:0]  p5,
  input  logic [PIX_W-1:0]  p6,
  input  logic [PIX_W-1:0]  p7,
  input  logic [PIX_W-1:0]  p8,
  input  logic [USER_W-1:0] in_user,
  input  logic [1:0]        cfg_mode,
  input  logic [PIX_W+2:0]  cfg_thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic [1:0]        out_dir,
  output logic              out_edge,
  output logic [USER_W-1:0] out_user
);

  localparam int GW = PIX_W + 3;
  localparam int AW = PIX_W + 2;

  logic                    r_v1, r_v2, r_v3;
  logic signed [GW-1:0]    r_gx, r_gy;
  logic [1:0]              r_md1, r_md2;
  logic [GW-1:0]           r_th1, r_th2;
  logic [USER_W-1:0]       r_u1, r_u2, r_u3;
  logic [AW-1:0]           r_ax, r_ay, r_mx, r_mn;
  logic                    r_sx, r_sy;
  logic [PIX_W-1:0]        r_data;
  logic [1:0]              r_dir;
  logic                    r_edge;

  logic                    w_adv;
  logic signed [GW-1:0]    w_gx, w_gy;
  logic [AW-1:0]           w_ax, w_ay;
  logic                    w_x_ge_y;
  logic [GW-1:0]           w_l1, w_l2, w_m, w_ms;
  logic                    w_edge;
  logic [PIX_W-1:0]        w_data;
  logic                    w_dx, w_dy;
  logic [1:0]              w_dir;

  function automatic logic signed [GW-1:0] f_ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign w_adv    = ~r_v3 | out_ready;
  assign in_ready = w_adv;

  // Range is bounded by 4*(2^PIX_W-1), so GW signed bits never wrap.
  assign w_gx = (f_ext(p2) - f_ext(p0)) + ((f_ext(p5) - f_ext(p3)) <<< 1) + (f_ext(p8) - f_ext(p6));
  assign w_gy = (f_ext(p0) - f_ext(p6)) + ((f_ext(p1) - f_ext(p7)) <<< 1) + (f_ext(p2) - f_ext(p8));

  assign w_ax     = AW'(r_gx[GW-1] ? -r_gx : r_gx);
  assign w_ay     = AW'(r_gy[GW-1] ? -r_gy : r_gy);
  assign w_x_ge_y = (w_ax >= w_ay);

  assign w_l1 = {1'b0, r_ax} + {1'b0, r_ay};
  assign w_l2 = {1'b0, r_mx} + {2'b00, r_mn[AW-1:1]};

  always_comb begin
    w_m = w_l1;
    case (r_md2)
      2'd1:    w_m = {1'b0, r_mx};
      2'd2:    w_m = w_l2;
      default: w_m = w_l1;
    endcase
  end

  assign w_ms   = w_m >> SHIFT;
  assign w_edge = (w_ms >= r_th2);

  always_comb begin
    w_data = w_ms[PIX_W-1:0];
    if (r_md2 == 2'd3)
      w_data = w_edge ? '1 : '0;
    else if (|w_ms[GW-1:PIX_W])
      w_data = '1;
  end

  // gx=gy=0 falls into the horizontal bucket via the first compare.
  assign w_dx  = ({r_ay, 1'b0} <= {1'b0, r_ax});
  assign w_dy  = ({r_ax, 1'b0} <= {1'b0, r_ay});
  assign w_dir = w_dx ? 2'd0 : (w_dy ? 2'd2 : ((r_sx == r_sy) ? 2'd1 : 2'd3));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_gx   <= '0;
      r_gy   <= '0;
      r_md1  <= '0;
      r_md2  <= '0;
      r_th1  <= '0;
      r_th2  <= '0;
      r_u1   <= '0;
      r_u2   <= '0;
      r_u3   <= '0;
      r_ax   <= '0;
      r_ay   <= '0;
      r_mx   <= '0;
      r_mn   <= '0;
      r_sx   <= 1'b0;
      r_sy   <= 1'b0;
      r_data <= '0;
      r_dir  <= '0;
      r_edge <= 1'b0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_gx   <= w_gx;
      r_gy   <= w_gy;
      r_md1  <= cfg_mode;
      r_th1  <= cfg_thresh;
      r_u1   <= in_user;

      r_v2   <= r_v1;
      r_ax   <= w_ax;
      r_ay   <= w_ay;
      r_mx   <= w_x_ge_y ? w_ax : w_ay;
      r_mn   <= w_x_ge_y ? w_ay : w_ax;
      r_sx   <= r_gx[GW-1];
      r_sy   <= r_gy[GW-1];
      r_md2  <= r_md1;
      r_th2  <= r_th1;
      r_u2   <= r_u1;

      r_v3   <= r_v2;
      r_data <= w_data;
      r_dir  <= w_dir;
      r_edge <= w_edge;
      r_u3   <= r_u2;
    end
  end

  assign out_valid = r_v3;
  assign out_data  = r_data;
  assign out_dir   = r_dir;
  assign out_edge  = r_edge;
  assign out_user  = r_u3;

endmodule

// File: tb/tb_sobel_pipe.sv
// Bench for sobel_pipe: two instances (SHIFT=0 and SHIFT=2) share one input stream and handshake.
module tb_sobel_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
  logic [3:0] in_user;
  logic [1:0] cfg_mode;
  logic [10:0] cfg_thresh;

  logic       rdy0, ov0, oe0;
  logic [7:0] od0;
  logic [1:0] odir0;
  logic [3:0] ou0;
  logic       rdy2, ov2, oe2;
  logic [7:0] od2;
  logic [1:0] odir2;
  logic [3:0] ou2;

  always #5 clk = ~clk;

  sobel_pipe #(.PIX_W(8), .USER_W(4), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .in_user(in_user), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_dir(odir0),
    .out_edge(oe0), .out_user(ou0));

  sobel_pipe #(.PIX_W(8), .USER_W(4), .SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .in_user(in_user), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_dir(odir2),
    .out_edge(oe2), .out_user(ou2));

  typedef struct packed {
    logic [7:0] d0;
    logic [1:0] dir;
    logic       e0;
    logic [7:0] d2;
    logic       e2;
    logic [3:0] user;
  } res_t;

  typedef struct packed {
    logic [7:0]  a0, a1, a2, a3, a5, a6, a7, a8;
    logic [1:0]  mode;
    logic [10:0] th;
    res_t        exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t got_q[$];
  bit   sb_en = 1'b0;
  bit   held = 1'b0;
  res_t prev_g;
  bit   s_acc, s_emit, s_ov, s_rdy;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic straight from the gradient / norm / quantisation rules.
  function automatic res_t model(input int a0, a1, a2, a3, a5, a6, a7, a8,
                                 input int mode, th, user);
    int gx, gy, ax, ay, mx, mn, m, ms2, dir;
    res_t r;
    gx = (a2 - a0) + 2 * (a5 - a3) + (a8 - a6);
    gy = (a0 - a6) + 2 * (a1 - a7) + (a2 - a8);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    case (mode)
      1:       m = mx;
      2:       m = mx + mn / 2;
      default: m = ax + ay;
    endcase
    if (2 * ay <= ax)              dir = 0;
    else if (2 * ax <= ay)         dir = 2;
    else if ((gx > 0) == (gy > 0)) dir = 1;
    else                           dir = 3;
    ms2    = m / 4;
    r.dir  = 2'(dir);
    r.e0   = (m >= th);
    r.e2   = (ms2 >= th);
    r.d0   = (mode == 3) ? (r.e0 ? 8'hff : 8'h00) : ((m > 255) ? 8'hff : 8'(m));
    r.d2   = (mode == 3) ? (r.e2 ? 8'hff : 8'h00) : ((ms2 > 255) ? 8'hff : 8'(ms2));
    r.user = 4'(user);
    return r;
  endfunction

  function automatic vec_t mkv(input int a0, a1, a2, a3, a5, a6, a7, a8, mode, th,
                               input int d0, dir, e0, d2, e2, user);
    vec_t v;
    v.a0 = 8'(a0); v.a1 = 8'(a1); v.a2 = 8'(a2); v.a3 = 8'(a3);
    v.a5 = 8'(a5); v.a6 = 8'(a6); v.a7 = 8'(a7); v.a8 = 8'(a8);
    v.mode = 2'(mode); v.th = 11'(th);
    v.exp.d0 = 8'(d0); v.exp.dir = 2'(dir); v.exp.e0 = 1'(e0);
    v.exp.d2 = 8'(d2); v.exp.e2 = 1'(e2); v.exp.user = 4'(user);
    return v;
  endfunction

  function automatic logic [7:0] rpix();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hff;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic rand_win();
    p0 = rpix(); p1 = rpix(); p2 = rpix(); p3 = rpix();
    p5 = rpix(); p6 = rpix(); p7 = rpix(); p8 = rpix();
    cfg_mode   = 2'($urandom_range(0, 3));
    cfg_thresh = 11'($urandom_range(0, 1100));
  endtask

  // One handshake cycle: called right after a falling edge with inputs set.
  task automatic cycle();
    res_t g, e;
    #1;
    s_acc  = in_valid & rdy0;
    s_emit = ov0 & out_ready;
    s_ov   = ov0;
    s_rdy  = rdy0;
    g = '{d0: od0, dir: odir0, e0: oe0, d2: od2, e2: oe2, user: ou0};
    if (sb_en) begin
      if (held) begin
        chk("hold_outputs", 32'(g), 32'(prev_g));
        chk("hold_valid", 32'(ov0), 32'd1);
      end
      if (s_emit) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stream_result", 32'(g), 32'(e));
          got_q.push_back(g);
        end
      end
      if (s_acc)
        exp_q.push_back(model(p0, p1, p2, p3, p5, p6, p7, p8,
                              int'(cfg_mode), int'(cfg_thresh), int'(in_user)));
      held   = ov0 & ~out_ready;
      prev_g = g;
    end
    @(negedge clk);
  endtask

  task automatic send_one(input vec_t v, input int idx);
    int n;
    p0 = v.a0; p1 = v.a1; p2 = v.a2; p3 = v.a3;
    p5 = v.a5; p6 = v.a6; p7 = v.a7; p8 = v.a8;
    cfg_mode = v.mode; cfg_thresh = v.th; in_user = v.exp.user;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", idx), 32'(rdy0), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    #1;
    while (!ov0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(n), 32'd3);
    chk($sformatf("v%0d_data0", idx), 32'(od0), 32'(v.exp.d0));
    chk($sformatf("v%0d_dir", idx), 32'(odir0), 32'(v.exp.dir));
    chk($sformatf("v%0d_edge0", idx), 32'(oe0), 32'(v.exp.e0));
    chk($sformatf("v%0d_data2", idx), 32'(od2), 32'(v.exp.d2));
    chk($sformatf("v%0d_edge2", idx), 32'(oe2), 32'(v.exp.e2));
    chk($sformatf("v%0d_user", idx), 32'(ou0), 32'(v.exp.user));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i, nemit, cyc;
    //          a0  a1  a2  a3  a5  a6  a7  a8 md  th    d0 dir e0  d2 e2 user
    tbl[0]  = mkv(0,  0, 255, 0, 255, 0,  0, 255, 0, 100, 255, 0, 1, 255, 1, 0);
    tbl[1]  = mkv(0,  0,  10, 0,   0, 0,  0,   0, 0, 100,  20, 1, 0,   5, 0, 1);
    tbl[2]  = mkv(0,  0,  10, 0,   0, 0,  0,   0, 1, 100,  10, 1, 0,   2, 0, 2);
    tbl[3]  = mkv(0,  0,  10, 0,   0, 0,  0,   0, 2, 100,  15, 1, 0,   3, 0, 3);
    tbl[4]  = mkv(10, 0,   0, 0,   0, 0,  0,   0, 0, 100,  20, 3, 0,   5, 0, 4);
    tbl[5]  = mkv(0,  0, 255, 0, 255, 0,  0, 255, 3, 300, 255, 0, 1,   0, 0, 5);
    tbl[6]  = mkv(0,  0,   0, 0, 255, 0,  0, 255, 3, 256, 255, 0, 1,   0, 0, 6);
    tbl[7]  = mkv(0,  0,  10, 0,   0, 0,  0,   0, 0,  20,  20, 1, 1,   5, 0, 7);
    tbl[8]  = mkv(100,100,100,0,   0, 0,  0,   0, 1, 400, 255, 2, 1, 100, 0, 8);
    tbl[9]  = mkv(0, 10,  30, 0,   0, 0,  0,   0, 2,  65,  65, 1, 1,  16, 0, 9);
    tbl[10] = mkv(0,  0,   0, 0,   0, 200, 0,  0, 1, 201, 200, 1, 0,  50, 0, 10);
    tbl[11] = mkv(0,  0,   0, 0,   0, 0,  0, 200, 0, 2047, 255, 3, 0, 100, 0, 11);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    p0 = 0; p1 = 0; p2 = 0; p3 = 0; p5 = 0; p6 = 0; p7 = 0; p8 = 0;
    in_user = 0; cfg_mode = 0; cfg_thresh = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid0", 32'(ov0), 32'd0);
    chk("rst_data0", 32'(od0), 32'd0);
    chk("rst_dir0", 32'(odir0), 32'd0);
    chk("rst_edge0", 32'(oe0), 32'd0);
    chk("rst_user0", 32'(ou0), 32'd0);
    chk("rst_valid2", 32'(ov2), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(rdy0), 32'd1);
    @(negedge clk);

    for (int k = 0; k < 12; k++) send_one(tbl[k], k);

    // Ten-window stream with a five-cycle output stall in the middle.
    sb_en = 1'b1; held = 1'b0; got_q.delete();
    i = 0; nemit = 0; cyc = 0;
    while (nemit < 10 && cyc < 200) begin
      in_valid  = (i < 10);
      in_user   = 4'(i);
      rand_win();
      out_ready = !(cyc >= 6 && cyc < 11);
      cycle();
      if (cyc == 10) begin
        chk("stall_in_ready", 32'(s_rdy), 32'd0);
        chk("stall_out_valid", 32'(s_ov), 32'd1);
      end
      if (nemit > 0 && out_ready) chk("stream_no_gap", 32'(s_ov), 32'd1);
      if (s_acc) i++;
      if (s_emit) nemit++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(nemit), 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("stream_user%0d", k), 32'(got_q[k].user), 32'(k));

    // Mode change on the cycle after acceptance only affects the following window.
    got_q.delete();
    p0 = 0; p1 = 0; p2 = 10; p3 = 0; p5 = 0; p6 = 0; p7 = 0; p8 = 0;
    cfg_mode = 2'd0; cfg_thresh = 11'd100; in_user = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("cfg_first_accepted", 32'(s_acc), 32'd1);
    cfg_mode = 2'd1; in_user = 4'd2;
    cycle();
    in_valid = 1'b0;
    repeat (6) cycle();
    chk("cfg_count", 32'(got_q.size()), 32'd2);
    chk("cfg_first_l1", 32'(got_q[0].d0), 32'd20);
    chk("cfg_second_linf", 32'(got_q[1].d0), 32'd10);

    // Random traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_user   = 4'($urandom_range(0, 15));
      rand_win();
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three windows in flight.
    p0 = 0; p1 = 0; p2 = 255; p3 = 0; p5 = 255; p6 = 0; p7 = 0; p8 = 255;
    cfg_mode = 2'd0; cfg_thresh = 11'd100; in_user = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(ov0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid0", 32'(ov0), 32'd0);
    chk("mid_rst_data0", 32'(od0), 32'd0);
    chk("mid_rst_edge0", 32'(oe0), 32'd0);
    chk("mid_rst_user0", 32'(ou0), 32'd0);
    chk("mid_rst_valid2", 32'(ov2), 32'd0);
    chk("mid_rst_data2", 32'(od2), 32'd0);
    sb_en = 1'b0; held = 1'b0; exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("post_rst_idle", 32'(ov0), 32'd0);
      @(negedge clk);
    end
    send_one(tbl[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
